// File: rtl/sram_mem_controller.sv
// sram_mem_controller: bridges a 32-bit MEM-stage load/store port onto a
// 16-bit asynchronous SRAM. Each word is moved as two halfword accesses
// (low half first), each stretched over WAIT_CYCLES+1 clocks; ready stays
// low while an access is in flight so the pipeline freezes.
module sram_mem_controller #(
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int          ADDR_W      = 18,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       address,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              ready,
   output logic [ADDR_W-1:0] sram_addr,
   inout  wire  [15:0]       sram_dq,
   output logic              sram_we_n,
   output logic              sram_oe_n,
   output logic              sram_ce_n,
   output logic              sram_ub_n,
   output logic              sram_lb_n
);

   localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOW,
      S_HIGH,
      S_DONE
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_is_write;
   logic [31:0]         r_wdata;
   logic [ADDR_W-2:0]   r_word;
   logic [31:0]         r_readdata;

   logic [31:0]         w_offset;
   logic                w_unused;
   logic                w_last;
   logic                w_active;
   logic                w_half;
   logic                w_drive;

   // Byte offset into data memory; the word index is bits [ADDR_W:2], the
   // byte lane and the bits above the SRAM range are deliberately dropped.
   assign w_offset = address - BASE_ADDR;
   assign w_unused = ^{w_offset[31:ADDR_W+1], w_offset[1:0]};

   assign w_last   = (r_cnt == CNT_W'(WAIT_CYCLES));
   assign w_active = (r_state == S_LOW) || (r_state == S_HIGH);
   assign w_half   = (r_state == S_HIGH);
   assign w_drive  = w_active && r_is_write;

   // SRAM strobes decode directly from registered state so they are stable
   // for the whole half-access; WE rises on the final cycle of each half so
   // address and data are held past the WE rising edge.
   assign sram_addr = w_active ? {r_word, w_half} : '0;
   assign sram_oe_n = ~(w_active && !r_is_write);
   assign sram_we_n = ~(w_drive && !w_last);
   assign sram_dq   = w_drive ? (w_half ? r_wdata[31:16] : r_wdata[15:0]) : 16'hzzzz;
   assign sram_ce_n = 1'b0;
   assign sram_ub_n = 1'b0;
   assign sram_lb_n = 1'b0;

   // In IDLE ready only drops when a request is pending, so a pipeline with
   // no memory op never stalls.
   assign ready    = (r_state == S_DONE) || ((r_state == S_IDLE) && !(read || write));
   assign readdata = r_readdata;

   // Access sequencer: latch the request in IDLE, walk LOW then HIGH halves,
   // capture read data on the edge leaving each half, then one DONE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_is_write <= 1'b0;
         r_wdata    <= '0;
         r_word     <= '0;
         r_readdata <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (write) begin
                  r_is_write <= 1'b1;
                  r_wdata    <= writedata;
                  r_word     <= w_offset[ADDR_W:2];
                  r_state    <= S_LOW;
               end else if (read) begin
                  r_is_write <= 1'b0;
                  r_word     <= w_offset[ADDR_W:2];
                  r_state    <= S_LOW;
               end
            end
            S_LOW: begin
               if (w_last) begin
                  r_cnt   <= '0;
                  r_state <= S_HIGH;
                  if (!r_is_write) begin
                     r_readdata[15:0] <= sram_dq;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_HIGH: begin
               if (w_last) begin
                  r_cnt   <= '0;
                  r_state <= S_DONE;
                  if (!r_is_write) begin
                     r_readdata[31:16] <= sram_dq;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/sram_mem_controller.md
# sram_mem_controller

Multi-cycle controller that sits between the MIPS MEM stage and the board's external 16-bit asynchronous SRAM. It replaces the single-cycle on-chip data array. Each 32-bit word access from the pipeline is split into two 16-bit SRAM accesses. While an access is in flight the controller holds `ready` low so the pipeline freezes.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: byte address where data memory starts. It is subtracted from `address` before word indexing.
- `ADDR_W`, default 18: SRAM address width.
- `WAIT_CYCLES`, default 1, legal range ≥1: wait cycles per 16-bit half. Each half occupies `WAIT_CYCLES+1` cycles.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `read` in 1: MEM-stage load request.
- `write` in 1: MEM-stage store request.
- `address` in 32: byte address (ALU result).
- `writedata` in 32: store data.
- `readdata` out 32: load data. Valid when `ready`=1 after a read.
- `ready` out 1: 1 means the request is complete or no request is pending. The pipeline freezes on `(read|write) & ~ready`.
- `sram_addr` out ADDR_W: SRAM halfword address.
- `sram_dq` inout 16: SRAM data bus. Driven only during writes, high-Z otherwise.
- `sram_we_n` out 1: active-low write enable.
- `sram_oe_n` out 1: active-low output enable.
- `sram_ce_n`, `sram_ub_n`, `sram_lb_n` out 1 each: tied 0.

## Operation
- Address map:
  - word = (`address` − `BASE_ADDR`) >> 2, computed modulo 2^32 with no range check.
  - `sram_addr` = {word[ADDR_W-2:0], half}; half=0 selects bits [15:0], half=1 selects bits [31:16].
  - `address[1:0]` is ignored.
- FSM states: IDLE, LOW, HIGH, DONE. A counter `cnt` runs 0..`WAIT_CYCLES` within LOW and HIGH.
- IDLE:
  - `ready` = ~(`read`|`write`), combinational.
  - If `write`: latch `writedata` and the op, go to LOW.
  - Else if `read`: latch the op, go to LOW.
  - `write` has priority when both are asserted; the access is a store.
- LOW (half=0), then HIGH (half=1). Each lasts `WAIT_CYCLES+1` cycles:
  - Read: `sram_oe_n`=0 and `sram_we_n`=1. On the edge leaving the state, `sram_dq` is captured into `readdata[15:0]` (LOW) or `readdata[31:16]` (HIGH).
  - Write: `sram_oe_n`=1 and `sram_dq` is driven with the latched half for the whole state. `sram_we_n`=0 while `cnt`<`WAIT_CYCLES` and 1 on the final cycle, giving address and data hold past the rising edge of WE.
  - `sram_addr` is stable for the whole state. `ready`=0.
- DONE: lasts one cycle with `ready`=1 and SRAM signals idle. Then unconditionally IDLE. A new request is evaluated only in IDLE.
- `readdata` holds its value until overwritten by the next read. Writes do not alter it.
- Idle SRAM outputs: `sram_we_n`=1, `sram_oe_n`=1, `sram_dq`=Z, `sram_addr`=0.

## Timing
- Reset values: state=IDLE, `cnt`=0, `readdata`=0, `sram_we_n`=1, `sram_oe_n`=1, `sram_dq`=Z, `sram_addr`=0. `ready` follows the IDLE rule.
- Reset is evaluated before every other transition. Reset during LOW/HIGH aborts the access: the next cycle is IDLE with the SRAM idle. A partially written word is acceptable.
- Latency: request first seen in IDLE at cycle 0. LOW occupies cycles 1..W+1, HIGH occupies W+2..2W+2, DONE is cycle 2W+3 with `ready`=1. For W=1, `ready` rises in cycle 5.
- The pipeline advances on the DONE edge. The cycle after DONE is IDLE, so a back-to-back request is seen there and starts a new 2W+4-cycle access.
- `read`/`write`/`address`/`writedata` may change after the IDLE edge without affecting the in-flight access, because they are latched.

## Test plan
- Store then load, W=1: write 0xDEADBEEF to 1028. Required:
  - SRAM addr 2 receives 0xBEEF, addr 3 receives 0xDEAD.
  - `ready` is high only in cycle 5.
  - A subsequent read of 1028 returns 0xDEADBEEF with `ready` in cycle 5.
- Cycle-accurate write waveform, W=2: `sram_we_n` is low 2 cycles and high 1 cycle per half. `sram_dq` stays stable across the WE rising edge. `ready` rises in cycle 7.
- Simultaneous `read`=`write`=1 at 1024 with data 0x12345678: treated as a store. SRAM addr 0/1 receive 0x5678/0x1234. `readdata` is unchanged.
- Back-to-back reads of 1024 and 1032: the second access starts the cycle after DONE. SRAM addresses 0,1 then 4,5.
- Reset asserted mid-HIGH of a read: the next cycle is IDLE with `readdata`=0, `sram_oe_n`=1, `sram_dq`=Z. With no request pending, `ready`=1.
- Idle, no request: `ready`=1, `sram_we_n`=`sram_oe_n`=1, bus Z. The FSM stays in IDLE.
